// File: rtl/alu_exec_ctrl.sv
// Sequential initiator for the 32-bit combinational ALU: register file, command
// handshake, IDLE -> EXEC -> WB sequencing, result capture and write-back.
module alu_exec_ctrl #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_ra,
  input  logic [ADDR_W-1:0] cmd_rb,
  input  logic [ADDR_W-1:0] cmd_rw,
  input  logic              cmd_we,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_f,
  input  logic              alu_zf,
  input  logic              alu_of,
  output logic              res_valid,
  output logic [DATA_W-1:0] res_data,
  output logic              res_zf,
  output logic              res_of,
  output logic              res_err,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data,
  output logic [1:0]        dbg_state
);

  localparam int NREG = 1 << ADDR_W;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE with no load pending.
  logic [1:0]        state_q, state_d;
  logic [DATA_W-1:0] rf_q [NREG];
  logic [DATA_W-1:0] alu_a_q, alu_b_q;
  logic [3:0]        alu_op_q;
  logic [ADDR_W-1:0] rw_q;
  logic              we_q, err_q;
  logic [DATA_W-1:0] res_data_q;
  logic              res_zf_q, res_of_q, res_err_q;
  logic              accept;
  logic              cmd_err;
  logic [DATA_W-1:0] rd_a, rd_b;

  assign cmd_ready = (state_q == S_IDLE) && !ld_en;
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_err   = (cmd_op > 4'd8);

  // r0 is hard-wired to zero on every read path.
  assign rd_a     = (cmd_ra == '0)   ? '0 : rf_q[cmd_ra];
  assign rd_b     = (cmd_rb == '0)   ? '0 : rf_q[cmd_rb];
  assign dbg_data = (dbg_addr == '0) ? '0 : rf_q[dbg_addr];

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_WB;
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      rw_q       <= '0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      res_data_q <= '0;
      res_zf_q   <= 1'b0;
      res_of_q   <= 1'b0;
      res_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && ld_en && ld_addr != '0) rf_q[ld_addr] <= ld_data;
      if (accept) begin
        alu_a_q  <= rd_a;
        alu_b_q  <= rd_b;
        alu_op_q <= cmd_err ? 4'd0 : cmd_op;
        rw_q     <= cmd_rw;
        we_q     <= cmd_we;
        err_q    <= cmd_err;
      end
      if (state_q == S_EXEC) begin
        res_data_q <= err_q ? '0 : alu_f;
        res_zf_q   <= err_q ? 1'b0 : alu_zf;
        res_of_q   <= err_q ? 1'b0 : alu_of;
        res_err_q  <= err_q;
      end
      // Write-back lands before IDLE so the next command reads the new value.
      if (state_q == S_WB && we_q && !err_q && rw_q != '0) rf_q[rw_q] <= res_data_q;
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_op    = alu_op_q;
  assign res_valid = (state_q == S_WB);
  assign res_data  = res_data_q;
  assign res_zf    = res_zf_q;
  assign res_of    = res_of_q;
  assign res_err   = res_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: behavioural ALU stub, register-file model, scenario tasks.
module tb_alu_exec_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [3:0]  cmd_op;
  logic [4:0]  cmd_ra, cmd_rb, cmd_rw;
  logic        ld_en;
  logic [4:0]  ld_addr;
  logic [31:0] ld_data;
  logic [31:0] alu_a, alu_b, alu_f;
  logic [3:0]  alu_op;
  logic        alu_zf, alu_of;
  logic        res_valid, res_zf, res_of, res_err;
  logic [31:0] res_data;
  logic [4:0]  dbg_addr;
  logic [31:0] dbg_data;
  logic [1:0]  dbg_state;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] model_rf [32];

  always #5 clk = ~clk;

  alu_exec_ctrl #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_ra(cmd_ra), .cmd_rb(cmd_rb), .cmd_rw(cmd_rw), .cmd_we(cmd_we),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .alu_f(alu_f), .alu_zf(alu_zf), .alu_of(alu_of),
    .res_valid(res_valid), .res_data(res_data), .res_zf(res_zf), .res_of(res_of),
    .res_err(res_err), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_state(dbg_state)
  );

  // Team ALU behaviour: 0 and, 1 or, 2 xor, 3 nor, 4 add, 5 sub, 6 slt, 7 sll (B << A), 8 seq.
  function automatic logic [31:0] ref_f(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0: return a & b;
      4'd1: return a | b;
      4'd2: return a ^ b;
      4'd3: return ~(a | b);
      4'd4: return a + b;
      4'd5: return a - b;
      4'd6: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd7: return b << a[4:0];
      4'd8: return (a == b) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic ref_of(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint s;
    if (op == 4'd4) s = longint'($signed(a)) + longint'($signed(b));
    else if (op == 4'd5) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s > 64'sd2147483647) || (s < -64'sd2147483648);
  endfunction

  assign alu_f  = ref_f(alu_op, alu_a, alu_b);
  assign alu_zf = (ref_f(alu_op, alu_a, alu_b) == 32'd0);
  assign alu_of = ref_of(alu_op, alu_a, alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input int a);
    dbg_addr = a[4:0];
    #1;
    total_cnt++;
    if (dbg_data !== model_rf[a]) $display("FAIL reg_r%0d: got %h expected %h", a, dbg_data, model_rf[a]);
    else pass_cnt++;
  endtask

  task automatic load(input int a, input logic [31:0] d);
    ld_en = 1'b1; ld_addr = a[4:0]; ld_data = d;
    tick();
    ld_en = 1'b0;
    if (a != 0) model_rf[a] = d;
  endtask

  // Drive one command through accept, EXEC and WB, checking every stage.
  task automatic run_cmd(input logic [3:0] op, input int ra, input int rb, input int rw, input logic we);
    int n;
    logic [31:0] a, b, f;
    logic err, zf, of;
    n = 0;
    #1;
    while (!cmd_ready && n < 10) begin tick(); n++; end
    total_cnt++;
    if (!cmd_ready) begin $display("FAIL ready_timeout: cmd_ready=%b expected 1", cmd_ready); return; end
    pass_cnt++;
    a = model_rf[ra]; b = model_rf[rb];
    err = (op > 4'd8);
    f  = err ? 32'd0 : ref_f(op, a, b);
    zf = err ? 1'b0 : (f == 32'd0);
    of = err ? 1'b0 : ref_of(op, a, b);
    cmd_op = op; cmd_ra = ra[4:0]; cmd_rb = rb[4:0]; cmd_rw = rw[4:0]; cmd_we = we;
    cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    total_cnt++; if (alu_a !== a) $display("FAIL exec_alu_a: got %h expected %h", alu_a, a); else pass_cnt++;
    total_cnt++; if (alu_b !== b) $display("FAIL exec_alu_b: got %h expected %h", alu_b, b); else pass_cnt++;
    total_cnt++; if (alu_op !== (err ? 4'd0 : op)) $display("FAIL exec_alu_op: got %h expected %h", alu_op, err ? 4'd0 : op); else pass_cnt++;
    total_cnt++; if (res_valid !== 1'b0 || cmd_ready !== 1'b0) $display("FAIL exec_flags: res_valid=%b cmd_ready=%b expected 0/0", res_valid, cmd_ready); else pass_cnt++;
    tick();
    total_cnt++; if (res_valid !== 1'b1) $display("FAIL wb_res_valid: got %b expected 1", res_valid); else pass_cnt++;
    total_cnt++; if (res_data !== f) $display("FAIL wb_res_data: got %h expected %h", res_data, f); else pass_cnt++;
    total_cnt++; if ({res_zf, res_of, res_err} !== {zf, of, err}) $display("FAIL wb_flags: zf/of/err got %b%b%b expected %b%b%b", res_zf, res_of, res_err, zf, of, err); else pass_cnt++;
    tick();
    total_cnt++; if (res_valid !== 1'b0 || cmd_ready !== 1'b1) $display("FAIL idle_return: res_valid=%b cmd_ready=%b expected 0/1", res_valid, cmd_ready); else pass_cnt++;
    if (we && !err && rw != 0) model_rf[rw] = f;
    check_reg(rw);
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_ra = '0; cmd_rb = '0; cmd_rw = '0; cmd_we = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    total_cnt++; if (cmd_ready !== 1'b1 || res_valid !== 1'b0) $display("FAIL reset_handshake: ready=%b res_valid=%b expected 1/0", cmd_ready, res_valid); else pass_cnt++;
    total_cnt++; if ({alu_a, alu_b, alu_op} !== 68'd0) $display("FAIL reset_alu_outs: got %h %h %h expected zeros", alu_a, alu_b, alu_op); else pass_cnt++;
    total_cnt++; if ({res_data, res_zf, res_of, res_err} !== 35'd0) $display("FAIL reset_res: got %h %b%b%b expected zeros", res_data, res_zf, res_of, res_err); else pass_cnt++;
    check_reg(5);
    check_reg(31);
  endtask

  task automatic test_add_overflow();
    load(1, 32'h7FFF_FFFF);
    load(2, 32'h0000_0001);
    run_cmd(4'd4, 1, 2, 3, 1'b1);
    total_cnt++; if (model_rf[3] !== 32'h8000_0000) $display("FAIL add_ovf_model: got %h expected 80000000", model_rf[3]); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    load(1, 32'h1234_5678);
    run_cmd(4'd5, 1, 1, 4, 1'b1);
    run_cmd(4'd8, 4, 0, 5, 1'b1);
    check_reg(5);
  endtask

  task automatic test_slt_sll();
    load(6, 32'd4);
    load(7, 32'd1);
    run_cmd(4'd6, 7, 6, 8, 1'b1);
    run_cmd(4'd7, 6, 7, 9, 1'b1);
  endtask

  task automatic test_illegal_r0();
    run_cmd(4'hA, 1, 2, 3, 1'b1);
    run_cmd(4'hF, 2, 2, 4, 1'b1);
    run_cmd(4'd1, 1, 2, 0, 1'b1);
    check_reg(0);
    load(0, 32'hDEAD_BEEF);
    check_reg(0);
  endtask

  task automatic test_handshake();
    int accepts, last;
    accepts = 0; last = -1;
    cmd_op = 4'd2; cmd_ra = 5'd1; cmd_rb = 5'd2; cmd_rw = 5'd12; cmd_we = 1'b0;
    cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (cmd_ready) begin
        total_cnt++;
        if (last >= 0 && c - last != 3) $display("FAIL hs_gap: got %0d expected 3", c - last); else pass_cnt++;
        accepts++; last = c;
      end
      tick();
    end
    cmd_valid = 1'b0;
    total_cnt++; if (accepts != 4) $display("FAIL hs_accepts: got %0d expected 4", accepts); else pass_cnt++;
  endtask

  task automatic test_priority();
    logic [31:0] d;
    d = $urandom;
    #1;
    ld_en = 1'b1; ld_addr = 5'd10; ld_data = d;
    cmd_op = 4'd4; cmd_ra = 5'd10; cmd_rb = 5'd0; cmd_rw = 5'd11; cmd_we = 1'b1; cmd_valid = 1'b1;
    #1;
    total_cnt++; if (cmd_ready !== 1'b0) $display("FAIL prio_ready: got %b expected 0", cmd_ready); else pass_cnt++;
    tick();
    model_rf[10] = d;
    ld_en = 1'b0;
    total_cnt++; if (dbg_state !== 2'd0) $display("FAIL prio_no_accept: state %0d expected 0", dbg_state); else pass_cnt++;
    check_reg(10);
    total_cnt++; if (cmd_ready !== 1'b1) $display("FAIL prio_ready_next: got %b expected 1", cmd_ready); else pass_cnt++;
    tick();
    cmd_valid = 1'b0;
    total_cnt++; if (alu_a !== d || dbg_state !== 2'd1) $display("FAIL prio_accept: alu_a %h state %0d expected %h/1", alu_a, dbg_state, d); else pass_cnt++;
    repeat (2) tick();
    model_rf[11] = d;
    check_reg(11);
  endtask

  task automatic test_random();
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 2) == 0) load($urandom_range(0, 31), $urandom);
      run_cmd(4'($urandom_range(0, 11)), $urandom_range(0, 31), $urandom_range(0, 31),
              $urandom_range(0, 31), 1'($urandom_range(0, 1)));
    end
  endtask

  task automatic test_reset_mid();
    load(13, 32'hCAFE_0001);
    #1;
    cmd_op = 4'd4; cmd_ra = 5'd13; cmd_rb = 5'd13; cmd_rw = 5'd14; cmd_we = 1'b1; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) model_rf[i] = 32'd0;
    total_cnt++; if (dbg_state !== 2'd0 || res_valid !== 1'b0) $display("FAIL rmid_state: state %0d res_valid %b expected 0/0", dbg_state, res_valid); else pass_cnt++;
    total_cnt++; if ({alu_a, alu_b, alu_op, res_data, res_zf, res_of, res_err} !== 103'd0) $display("FAIL rmid_outputs: alu_a %h res_data %h expected zeros", alu_a, res_data); else pass_cnt++;
    check_reg(14);
    check_reg(13);
    tick();
    total_cnt++; if (res_valid !== 1'b0) $display("FAIL rmid_no_wb: res_valid %b expected 0", res_valid); else pass_cnt++;
    check_reg(14);
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_back_to_back();
    test_slt_sll();
    test_illegal_r0();
    test_handshake();
    test_priority();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

endmodule
